edge_detect_multi: RTL and testbench

- Parametrised N-channel edge detector.
- Per channel: input synchroniser, debounce FSM, per-channel edge mode (off/rise/fall/both), and a sticky event flag with clear.
- Output timing is selectable: Mealy (combinational pulse) or Moore (registered pulse).
- Sits between asynchronous/bouncy inputs (buttons, external strobes) and the synchronous control logic that consumes single-cycle event pulses.

---
 rtl/edge_pkg.sv | 26 ++
 rtl/edge_chan.sv | 146 ++++++++++++++
 rtl/edge_detect_multi.sv | 36 +++
 tb/tb_edge_detect_multi.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/edge_pkg.sv
// Shared types for the multi-channel edge detector: edge-mode encoding,
// debounce FSM states and the mode qualification helper.
package edge_pkg;

  typedef enum logic [1:0] {
    MODE_OFF  = 2'b00,
    MODE_RISE = 2'b01,
    MODE_FALL = 2'b10,
    MODE_BOTH = 2'b11
  } edge_mode_e;

  typedef enum logic [1:0] {
    S_LO,
    P_HI,
    S_HI,
    P_LO
  } deb_state_e;

  // Bit 0 of the mode enables rising edges, bit 1 enables falling edges.
  function automatic logic qualify(input edge_mode_e mode,
                                   input logic       rise_acc,
                                   input logic       fall_acc);
    return (mode[0] & rise_acc) | (mode[1] & fall_acc);
  endfunction

endpackage

// File: rtl/edge_chan.sv
// One edge-detector channel: input synchroniser, debounce FSM, mode
// qualification, optional registered pulse and a sticky event flag.
module edge_chan
  import edge_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEB_CYCLES  = 3,
  parameter int unsigned OUT_REG     = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_sig,
  input  logic [1:0] mode,
  input  logic       clr_sticky,
  output logic       edge_pulse,
  output logic       edge_sticky
);

  localparam int unsigned       CNT_W   = $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0]  ACC_CNT = CNT_W'(DEB_CYCLES - 1);
  localparam logic              NO_FILT = (DEB_CYCLES == 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  deb_state_e             state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   rise_acc;
  logic                   fall_acc;
  logic                   qual;
  logic                   sticky_d;
  logic                   sticky_q;

  // NOTE: sequential state uses non-blocking assignments and an async reset
  // in the sensitivity list, so reset clears state without waiting for clk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in_sig};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // The accept cycle is the one in which the new level has been seen for
  // DEB_CYCLES consecutive cycles; it drives the Mealy pulse directly.
  always_comb begin
    rise_acc = 1'b0;
    fall_acc = 1'b0;
    unique case (state_q)
      S_LO:    rise_acc = s & NO_FILT;
      P_HI:    rise_acc = s & (cnt_q == ACC_CNT);
      S_HI:    fall_acc = ~s & NO_FILT;
      P_LO:    fall_acc = ~s & (cnt_q == ACC_CNT);
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_LO;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        S_LO: begin
          if (s) begin
            if (rise_acc) begin
              state_q <= S_HI;
            end else begin
              state_q <= P_HI;
              cnt_q   <= CNT_W'(1);
            end
          end
        end
        P_HI: begin
          if (!s) begin
            state_q <= S_LO;
            cnt_q   <= '0;
          end else if (rise_acc) begin
            state_q <= S_HI;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_HI: begin
          if (!s) begin
            if (fall_acc) begin
              state_q <= S_LO;
            end else begin
              state_q <= P_LO;
              cnt_q   <= CNT_W'(1);
            end
          end
        end
        P_LO: begin
          if (s) begin
            state_q <= S_HI;
            cnt_q   <= '0;
          end else if (fall_acc) begin
            state_q <= S_LO;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= S_LO;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign qual = qualify(edge_mode_e'(mode), rise_acc, fall_acc);

  generate
    if (OUT_REG != 0) begin : g_moore
      logic pulse_q;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          pulse_q <= 1'b0;
        end else begin
          pulse_q <= qual;
        end
      end
      assign edge_pulse = pulse_q;
    end else begin : g_mealy
      assign edge_pulse = qual;
    end
  endgenerate

  // Set has priority over clear so an event arriving with a clear is kept.
  assign sticky_d = qual | (sticky_q & ~clr_sticky);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sticky_q <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign edge_sticky = sticky_q;

endmodule

// File: rtl/edge_detect_multi.sv
// N-channel edge detector: one independent edge_chan per input, with the
// per-channel two-bit mode field sliced out of the packed mode bus.
module edge_detect_multi #(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEB_CYCLES  = 3,
  parameter int unsigned OUT_REG     = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_CH-1:0]   in_sig,
  input  logic [2*N_CH-1:0] mode,
  input  logic [N_CH-1:0]   clr_sticky,
  output logic [N_CH-1:0]   edge_pulse,
  output logic [N_CH-1:0]   edge_sticky
);

  generate
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
      edge_chan #(
        .SYNC_STAGES (SYNC_STAGES),
        .DEB_CYCLES  (DEB_CYCLES),
        .OUT_REG     (OUT_REG)
      ) u_chan (
        .clk         (clk),
        .reset       (reset),
        .in_sig      (in_sig[i]),
        .mode        (mode[2*i +: 2]),
        .clr_sticky  (clr_sticky[i]),
        .edge_pulse  (edge_pulse[i]),
        .edge_sticky (edge_sticky[i])
      );
    end
  endgenerate

endmodule

// File: tb/tb_edge_detect_multi.sv
// Bench for edge_detect_multi: Mealy and Moore instances share stimulus and
// are compared every cycle against a run-length reference model via a queue.
module tb_edge_detect_multi;
  import edge_pkg::*;

  localparam int N  = 4;
  localparam int SS = 2;
  localparam int DB = 3;

  typedef struct packed {
    logic [N-1:0] p0;
    logic [N-1:0] p1;
    logic [N-1:0] st;
  } exp_t;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   in_sig;
  logic [2*N-1:0] mode;
  logic [N-1:0]   clr_sticky;
  logic [N-1:0]   pulse0, sticky0, pulse1, sticky1;

  logic           rst_v;
  logic [N-1:0]   in_v;
  logic [2*N-1:0] mode_v;
  logic [N-1:0]   clr_v;

  logic [SS-1:0]  m_sh [N];
  logic [N-1:0]   m_lvl;
  int             m_run [N];
  logic [N-1:0]   m_sticky;
  logic [N-1:0]   m_preg;

  exp_t           sb [$];
  int             pcnt [N] = '{default: 0};
  int             n_vec = 0;
  int             n_err = 0;
  int             base [N];

  always #5 clk = ~clk;

  edge_detect_multi #(
    .N_CH(N), .SYNC_STAGES(SS), .DEB_CYCLES(DB), .OUT_REG(0)
  ) u_dut0 (
    .clk(clk), .reset(reset), .in_sig(in_sig), .mode(mode),
    .clr_sticky(clr_sticky), .edge_pulse(pulse0), .edge_sticky(sticky0)
  );

  edge_detect_multi #(
    .N_CH(N), .SYNC_STAGES(SS), .DEB_CYCLES(DB), .OUT_REG(1)
  ) u_dut1 (
    .clk(clk), .reset(reset), .in_sig(in_sig), .mode(mode),
    .clr_sticky(clr_sticky), .edge_pulse(pulse1), .edge_sticky(sticky1)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, want, $time);
    end
  endtask

  // A new level is accepted once the synchronised input has differed from
  // the accepted level for DB consecutive cycles.
  function automatic logic [N-1:0] model_q();
    logic [N-1:0] q;
    logic         s;
    logic         acc;
    q = '0;
    for (int c = 0; c < N; c++) begin
      s    = m_sh[c][SS-1];
      acc  = (s != m_lvl[c]) && (m_run[c] + 1 >= DB);
      q[c] = acc && (s ? mode[2*c] : mode[2*c+1]);
    end
    return q;
  endfunction

  task automatic model_update();
    logic [N-1:0] q;
    logic         s;
    if (reset) begin
      for (int c = 0; c < N; c++) begin
        m_sh[c]  = '0;
        m_run[c] = 0;
      end
      m_lvl    = '0;
      m_sticky = '0;
      m_preg   = '0;
    end else begin
      q        = model_q();
      m_sticky = q | (m_sticky & ~clr_sticky);
      m_preg   = q;
      for (int c = 0; c < N; c++) begin
        s = m_sh[c][SS-1];
        if (s != m_lvl[c]) begin
          if (m_run[c] + 1 >= DB) begin
            m_lvl[c] = s;
            m_run[c] = 0;
          end else begin
            m_run[c]++;
          end
        end else begin
          m_run[c] = 0;
        end
        m_sh[c] = {m_sh[c][SS-2:0], in_sig[c]};
      end
    end
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    model_update();
    #1;
    reset      = rst_v;
    in_sig     = in_v;
    mode       = mode_v;
    clr_sticky = clr_v;
    if (reset) begin
      e = '0;
    end else begin
      e.p0 = model_q();
      e.p1 = m_preg;
      e.st = m_sticky;
    end
    sb.push_back(e);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("pulse_mealy", pulse0,  e.p0);
      check("pulse_moore", pulse1,  e.p1);
      check("sticky_mealy", sticky0, e.st);
      check("sticky_moore", sticky1, e.st);
    end
    for (int c = 0; c < N; c++) pcnt[c] += int'(pulse0[c]);
  end

  initial begin
    reset = 1'b1; in_sig = '0; mode = '1; clr_sticky = '0;
    rst_v = 1'b1; in_v = '0; mode_v = '1; clr_v = '0;

    run(3);
    @(negedge clk);
    check("rst_pulse",  {pulse1, pulse0},   '0);
    check("rst_sticky", {sticky1, sticky0}, '0);

    // Single qualified rise on ch0 in rise-only mode.
    mode_v[1:0] = MODE_RISE;
    rst_v = 1'b0;
    run(3);
    in_v[0] = 1'b1;
    run(4);
    @(negedge clk);
    check("s1_early", pulse0[0], 1'b0);
    tick();
    @(negedge clk);
    check("s1_pulse",       pulse0[0],  1'b1);
    check("s1_moore_wait",  pulse1[0],  1'b0);
    check("s1_sticky_wait", sticky0[0], 1'b0);
    tick();
    @(negedge clk);
    check("s1_pulse_end",  pulse0[0],  1'b0);
    check("s1_moore",      pulse1[0],  1'b1);
    check("s1_sticky",     sticky0[0], 1'b1);
    check("s1_sticky_reg", sticky1[0], 1'b1);
    tick();
    base[0] = pcnt[0];
    run(20);
    check("s1_no_repeat", pcnt[0] - base[0], 0);

    // Two-cycle glitch on ch1 must be rejected.
    in_v[1] = 1'b1;
    tick();
    base[1] = pcnt[1];
    tick();
    in_v[1] = 1'b0;
    run(10);
    check("s2_glitch", pcnt[1] - base[1], 0);
    @(negedge clk);
    check("s2_sticky", sticky0[1], 1'b0);

    // Fall-only mode on ch2: rise ignored, fall reported L cycles later.
    mode_v[5:4] = MODE_FALL;
    in_v[2] = 1'b1;
    tick();
    base[2] = pcnt[2];
    run(9);
    in_v[2] = 1'b0;
    run(4);
    @(negedge clk);
    check("s3_early", pulse0[2], 1'b0);
    tick();
    @(negedge clk);
    check("s3_fall_pulse", pulse0[2], 1'b1);
    run(6);
    check("s3_count", pcnt[2] - base[2], 1);

    // Square wave with period 16 on ch3, other channels quiet.
    mode_v = '1;
    in_v   = '0;
    run(10);
    for (int c = 0; c < N; c++) base[c] = pcnt[c];
    for (int p = 0; p < 4; p++) begin
      in_v[3] = 1'b1;
      run(8);
      in_v[3] = 1'b0;
      run(8);
    end
    run(8);
    check("s4_ch3_count", pcnt[3] - base[3], 8);
    for (int c = 0; c < 3; c++) check("s4_quiet", pcnt[c] - base[c], 0);

    // Clear coinciding with a new event: set wins; a later clear works.
    clr_v = '1;
    tick();
    clr_v = '0;
    tick();
    @(negedge clk);
    check("s5_cleared", sticky0[0], 1'b0);
    in_v[0] = 1'b1;
    run(4);
    clr_v[0] = 1'b1;
    tick();
    @(negedge clk);
    check("s5_pulse", pulse0[0], 1'b1);
    tick();
    @(negedge clk);
    check("s5_set_wins", sticky0[0], 1'b1);
    clr_v[0] = 1'b0;
    tick();
    @(negedge clk);
    check("s5_clear_late", sticky0[0], 1'b0);

    // Reset while ch0 is pending high, then release with ch0 held high.
    in_v[0] = 1'b0;
    run(8);
    in_v[0] = 1'b1;
    run(4);
    rst_v = 1'b1;
    tick();
    #1;
    check("s6_async_pulse",  {pulse1, pulse0},   '0);
    check("s6_async_sticky", {sticky1, sticky0}, '0);
    run(2);
    rst_v = 1'b0;
    tick();
    run(3);
    @(negedge clk);
    check("s6_early", pulse0[0], 1'b0);
    tick();
    @(negedge clk);
    check("s6_mealy",      pulse0[0], 1'b1);
    check("s6_moore_wait", pulse1[0], 1'b0);
    tick();
    @(negedge clk);
    check("s6_mealy_end", pulse0[0], 1'b0);
    check("s6_moore",     pulse1[0], 1'b1);

    run(6);
    @(negedge clk);
    @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
